// File: rtl/tst_dout_win_stats_if.sv
// AXI-Stream beat bus feeding the window-statistics checker.
interface tst_dout_win_stats_if #(
   parameter int LANES = 4
) ();
   logic                tvalid;
   logic                tready;
   logic [32*LANES-1:0] tdata;

   modport master (output tvalid, output tdata, input tready);
   modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/tst_dout_win_stats.sv
// Ramp checker that reduces an AXI-Stream sink to per-window beat/error/idle statistics.
// Optional first-error capture ports are enabled by defining TST_DOUT_ERR_CAPTURE_EN.
module tst_dout_win_stats #(
   parameter int LANES   = 4,
   parameter int WIN_LEN = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     test_en,
   input  logic [31:0]              total_beats,
   tst_dout_win_stats_if.slave      s_axis,
   output logic                     vld_o,
   output logic [6:0]               cnt_o,
   output logic [6:0]               err_o,
   output logic [11:0]              idl_o,
   output logic [15:0]              lat_o,
   output logic                     done_o
`ifdef TST_DOUT_ERR_CAPTURE_EN
   ,
   output logic [31:0]              first_err_idx_o,
   output logic [32*LANES-1:0]      first_err_data_o
`endif
);
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT_FIRST, ST_RUN, ST_DONE} state_t;
   localparam logic [6:0] WIN_LAST = 7'(WIN_LEN - 1);

   state_t           r_state;
   logic             r_en;
   logic             r_en_d;
   logic [31:0]      r_n;
   logic [31:0]      r_total;
   logic [15:0]      r_lat_cnt;
   logic [6:0]       r_win_cnt;
   logic [6:0]       r_acc_cnt;
   logic [6:0]       r_acc_err;
   logic [6:0]       r_acc_idl;
   logic             r_vld;
   logic             r_done;
   logic [6:0]       r_cnt;
   logic [6:0]       r_err;
   logic [6:0]       r_idl;
   logic [15:0]      r_lat;

   logic             w_start;
   logic             w_ready;
   logic             w_accept;
   logic             w_in_win;
   logic             w_idle;
   logic             w_beat_err;
   logic             w_last;
   logic             w_publish;
   logic [31:0]      w_base;
   logic [LANES-1:0] w_lane_err;
   logic [6:0]       w_cnt_sum;
   logic [6:0]       w_err_sum;
   logic [6:0]       w_idl_sum;

   assign w_start  = r_en & ~r_en_d;
   // Gating with r_en keeps a handshake from completing in the cycle an abort takes effect.
   assign w_ready  = r_en & ((r_state == ST_WAIT_FIRST) | (r_state == ST_RUN));
   assign w_accept = w_ready & s_axis.tvalid;
   // The cycle carrying the first beat is window cycle 0, even though it occurs in WAIT_FIRST.
   assign w_in_win = r_en & ((r_state == ST_RUN) | ((r_state == ST_WAIT_FIRST) & s_axis.tvalid));
   assign w_idle   = r_en & (r_state == ST_RUN) & ~s_axis.tvalid;
   assign w_base   = r_n * 32'(LANES);

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign w_lane_err[gi] = (s_axis.tdata[32*gi +: 32] != (w_base + 32'(gi)));
      end
   endgenerate

   assign w_beat_err = w_accept & (|w_lane_err);
   assign w_last     = w_accept & (r_n == (r_total - 32'd1));
   assign w_publish  = w_in_win & ((r_win_cnt == WIN_LAST) | w_last);
   assign w_cnt_sum  = r_acc_cnt + {6'd0, w_accept};
   assign w_err_sum  = r_acc_err + {6'd0, w_beat_err};
   assign w_idl_sum  = r_acc_idl + {6'd0, w_idle};

   assign s_axis.tready = w_ready;
   assign vld_o  = r_vld;
   assign cnt_o  = r_cnt;
   assign err_o  = r_err;
   assign idl_o  = {5'd0, r_idl};
   assign lat_o  = r_lat;
   assign done_o = r_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_en      <= 1'b0;
         r_en_d    <= 1'b0;
         r_n       <= '0;
         r_total   <= '0;
         r_lat_cnt <= '0;
         r_win_cnt <= '0;
         r_acc_cnt <= '0;
         r_acc_err <= '0;
         r_acc_idl <= '0;
         r_vld     <= 1'b0;
         r_done    <= 1'b0;
         r_cnt     <= '0;
         r_err     <= '0;
         r_idl     <= '0;
         r_lat     <= '0;
      end else begin
         r_en   <= test_en;
         r_en_d <= r_en;
         if (!r_en) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_start) begin
                     r_state   <= ST_WAIT_FIRST;
                     r_n       <= '0;
                     r_lat_cnt <= '0;
                     r_win_cnt <= '0;
                     r_acc_cnt <= '0;
                     r_acc_err <= '0;
                     r_acc_idl <= '0;
                     r_total   <= (total_beats == 32'd0) ? 32'd1 : total_beats;
                  end
               end
               ST_WAIT_FIRST, ST_RUN: begin
                  if (r_state == ST_WAIT_FIRST) begin
                     if (s_axis.tvalid) begin
                        r_state <= ST_RUN;
                        r_lat   <= r_lat_cnt;
                     end else if (r_lat_cnt != 16'hFFFF) begin
                        r_lat_cnt <= r_lat_cnt + 16'd1;
                     end
                  end
                  if (w_in_win) begin
                     if (w_accept) begin
                        r_n <= r_n + 32'd1;
                     end
                     if (w_publish) begin
                        r_cnt     <= w_cnt_sum;
                        r_err     <= w_err_sum;
                        r_idl     <= w_idl_sum;
                        r_vld     <= ~r_vld;
                        r_acc_cnt <= '0;
                        r_acc_err <= '0;
                        r_acc_idl <= '0;
                        r_win_cnt <= '0;
                     end else begin
                        r_acc_cnt <= w_cnt_sum;
                        r_acc_err <= w_err_sum;
                        r_acc_idl <= w_idl_sum;
                        r_win_cnt <= r_win_cnt + 7'd1;
                     end
                     if (w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

`ifdef TST_DOUT_ERR_CAPTURE_EN
   logic                r_err_seen;
   logic [31:0]         r_fe_idx;
   logic [32*LANES-1:0] r_fe_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_seen <= 1'b0;
         r_fe_idx   <= '0;
         r_fe_data  <= '0;
      end else if ((r_state == ST_IDLE) && w_start) begin
         r_err_seen <= 1'b0;
         r_fe_idx   <= '0;
         r_fe_data  <= '0;
      end else if (w_beat_err && !r_err_seen) begin
         r_err_seen <= 1'b1;
         r_fe_idx   <= r_n;
         r_fe_data  <= s_axis.tdata;
      end
   end

   assign first_err_idx_o  = r_fe_idx;
   assign first_err_data_o = r_fe_data;
`endif

endmodule

// File: tb/tb_tst_dout_win_stats.sv
// Directed bench for tst_dout_win_stats: ramp streams with gaps, idles, corruption, abort and reset.
module tb_tst_dout_win_stats;
   localparam int LANES = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                test_en;
   logic [31:0]         total_beats;
   logic                vld_o;
   logic [6:0]          cnt_o;
   logic [6:0]          err_o;
   logic [11:0]         idl_o;
   logic [15:0]         lat_o;
   logic                done_o;
`ifdef TST_DOUT_ERR_CAPTURE_EN
   logic [31:0]         first_err_idx_o;
   logic [32*LANES-1:0] first_err_data_o;
`endif

   always #5 clk = ~clk;

   tst_dout_win_stats_if #(.LANES(LANES)) axis_if ();

   tst_dout_win_stats #(.LANES(LANES), .WIN_LEN(64)) dut (
      .clk         (clk),
      .rst         (rst),
      .test_en     (test_en),
      .total_beats (total_beats),
      .s_axis      (axis_if),
      .vld_o       (vld_o),
      .cnt_o       (cnt_o),
      .err_o       (err_o),
      .idl_o       (idl_o),
      .lat_o       (lat_o),
      .done_o      (done_o)
`ifdef TST_DOUT_ERR_CAPTURE_EN
      ,
      .first_err_idx_o  (first_err_idx_o),
      .first_err_data_o (first_err_data_o)
`endif
   );

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Publish monitor: samples 1 time unit after each rising edge.
   logic        vld_prev = 1'b0;
   int          n_tog    = 0;
   logic [6:0]  pub_cnt[$];
   logic [6:0]  pub_err[$];
   logic [11:0] pub_idl[$];

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (vld_o !== vld_prev) begin
            n_tog++;
            pub_cnt.push_back(cnt_o);
            pub_err.push_back(err_o);
            pub_idl.push_back(idl_o);
            vld_prev = vld_o;
         end
      end
   end

   task automatic clear_mon();
      n_tog = 0;
      pub_cnt.delete();
      pub_err.delete();
      pub_idl.delete();
   endtask

   // which: 0 = cnt, 1 = err, 2 = idl; out-of-range reads give an impossible value.
   function automatic logic [11:0] pub_at(input int which, input int i);
      if (i >= pub_cnt.size()) return 12'hFFF;
      case (which)
         0:       return {5'd0, pub_cnt[i]};
         1:       return {5'd0, pub_err[i]};
         default: return pub_idl[i];
      endcase
   endfunction

   function automatic logic [32*LANES-1:0] beat_data(input int n, input int bad0, input int bad1);
      logic [32*LANES-1:0] d;
      for (int k = 0; k < LANES; k++) begin
         d[32*k +: 32] = n * LANES + k;
      end
      if (n == bad0 || n == bad1) d[64 +: 32] = d[64 +: 32] ^ 32'h0000_0100;
      return d;
   endfunction

   // mode 0: continuous tvalid after the gap; mode 1: tvalid low every 4th cycle after the gap.
   task automatic run_test(input string name, input int gap, input logic [31:0] total, input int mode,
                           input int abort_at, input int rst_at, input int bad0, input int bad1,
                           output int tog_before_first);
      int   eff;
      int   n;
      int   cyc;
      int   wait_cyc;
      int   limit;
      logic tv;
      logic tv_prev;
      logic tr_prev;
      logic stopped;
      eff = (total == 32'd0) ? 1 : int'(total);
      n = 0; cyc = 0; wait_cyc = 0; tv_prev = 1'b0; tr_prev = 1'b0; stopped = 1'b0;
      tog_before_first = -1;
      limit = gap + 4 * eff + 100;
      total_beats = total;
      test_en = 1'b1;
      @(negedge clk);
      while (!axis_if.tready && wait_cyc < 20) begin
         @(negedge clk);
         wait_cyc++;
      end
      check_val({name, " ready_after_start"}, 64'(axis_if.tready), 64'd1);
      for (int g = 0; g < limit; g++) begin
         if (tv_prev && tr_prev) n++;
         if (n == eff) break;
         if (n == abort_at) begin
            test_en = 1'b0;
            stopped = 1'b1;
            break;
         end
         if (n == rst_at) begin
            rst = 1'b1;
            test_en = 1'b0;
            stopped = 1'b1;
            break;
         end
         tv = (cyc >= gap) && (mode == 0 || ((cyc - gap) % 4) != 3);
         if (tv && tog_before_first < 0) tog_before_first = n_tog;
         axis_if.tvalid = tv;
         axis_if.tdata  = beat_data(n, bad0, bad1);
         tr_prev = axis_if.tready;
         tv_prev = tv;
         @(negedge clk);
         cyc++;
      end
      axis_if.tvalid = 1'b0;
      if (!stopped) check_val({name, " beats_accepted"}, 64'(n), 64'(eff));
      $display("run %s: gap=%0d total=%0d beats=%0d toggles=%0d", name, gap, total, n, n_tog);
   endtask

   task automatic idle_cycles(input int c);
      repeat (c) @(negedge clk);
   endtask

   int tb_first;
   int sum_cnt;

   initial begin
      rst = 1'b1; test_en = 1'b0; total_beats = '0;
      axis_if.tvalid = 1'b0; axis_if.tdata = '0;
      idle_cycles(3);
      check_val("rst vld_o", 64'(vld_o), 64'd0);
      check_val("rst cnt_o", 64'(cnt_o), 64'd0);
      check_val("rst idl_o", 64'(idl_o), 64'd0);
      check_val("rst lat_o", 64'(lat_o), 64'd0);
      check_val("rst done_o", 64'(done_o), 64'd0);
      check_val("rst tready", 64'(axis_if.tready), 64'd0);
      rst = 1'b0;
      idle_cycles(2);

      // Clean ramp, 10-cycle gap, 256 beats: last beat lands on a window end.
      clear_mon();
      run_test("t1", 10, 32'd256, 0, -1, -1, -1, -1, tb_first);
      idle_cycles(3);
      check_val("t1 lat_o", 64'(lat_o), 64'd10);
      check_val("t1 toggles_before_first", 64'(tb_first), 64'd0);
      check_val("t1 toggles", 64'(n_tog), 64'd4);
      for (int i = 0; i < 4; i++) begin
         check_val($sformatf("t1 w%0d cnt", i), 64'(pub_at(0, i)), 64'd64);
         check_val($sformatf("t1 w%0d err", i), 64'(pub_at(1, i)), 64'd0);
         check_val($sformatf("t1 w%0d idl", i), 64'(pub_at(2, i)), 64'd0);
      end
      check_val("t1 done_o", 64'(done_o), 64'd1);
      check_val("t1 tready_in_done", 64'(axis_if.tready), 64'd0);
      idle_cycles(70);
      check_val("t1 toggles_in_done", 64'(n_tog), 64'd4);
      test_en = 1'b0;
      idle_cycles(3);
      check_val("t1 done_o_after_drop", 64'(done_o), 64'd0);
      check_val("t1 cnt_o_hold", 64'(cnt_o), 64'd64);

      // Every 4th cycle idle, 96 beats: 48/16 then partial 48/15.
      clear_mon();
      run_test("t2", 3, 32'd96, 1, -1, -1, -1, -1, tb_first);
      idle_cycles(3);
      check_val("t2 lat_o", 64'(lat_o), 64'd3);
      check_val("t2 toggles", 64'(n_tog), 64'd2);
      check_val("t2 w0 cnt", 64'(pub_at(0, 0)), 64'd48);
      check_val("t2 w0 idl", 64'(pub_at(2, 0)), 64'd16);
      check_val("t2 w1 cnt", 64'(pub_at(0, 1)), 64'd48);
      check_val("t2 w1 idl", 64'(pub_at(2, 1)), 64'd15);
      sum_cnt = int'(pub_at(0, 0)) + int'(pub_at(0, 1));
      check_val("t2 sum_cnt", 64'(sum_cnt), 64'd96);
      check_val("t2 done_o", 64'(done_o), 64'd1);
      test_en = 1'b0;
      idle_cycles(3);

      // Word 2 corrupted on beats 5 and 70, no gap: first beat in first WAIT_FIRST cycle.
      clear_mon();
      run_test("t3", 0, 32'd128, 0, -1, -1, 5, 70, tb_first);
      idle_cycles(3);
      check_val("t3 lat_o", 64'(lat_o), 64'd0);
      check_val("t3 toggles", 64'(n_tog), 64'd2);
      check_val("t3 w0 err", 64'(pub_at(1, 0)), 64'd1);
      check_val("t3 w1 err", 64'(pub_at(1, 1)), 64'd1);
      check_val("t3 w1 cnt", 64'(pub_at(0, 1)), 64'd64);
`ifdef TST_DOUT_ERR_CAPTURE_EN
      check_val("t3 first_err_idx", 64'(first_err_idx_o), 64'd5);
      check_val("t3 first_err_w2", 64'(first_err_data_o[64 +: 32]), 64'h116);
      check_val("t3 first_err_w0", 64'(first_err_data_o[0 +: 32]), 64'd20);
`endif
      test_en = 1'b0;
      idle_cycles(3);

      // Latency saturation; total_beats=0 behaves as a single beat.
      clear_mon();
      run_test("t4", 65600, 32'd0, 0, -1, -1, -1, -1, tb_first);
      idle_cycles(3);
      check_val("t4 lat_o", 64'(lat_o), 64'hFFFF);
      check_val("t4 toggles_before_first", 64'(tb_first), 64'd0);
      check_val("t4 toggles", 64'(n_tog), 64'd1);
      check_val("t4 w0 cnt", 64'(pub_at(0, 0)), 64'd1);
      check_val("t4 w0 idl", 64'(pub_at(2, 0)), 64'd0);
      check_val("t4 done_o", 64'(done_o), 64'd1);
      test_en = 1'b0;
      idle_cycles(3);

      // Abort after 100 of 200 beats: only window 0 published.
      clear_mon();
      run_test("t5", 2, 32'd200, 0, 100, -1, -1, -1, tb_first);
      idle_cycles(80);
      check_val("t5 toggles", 64'(n_tog), 64'd1);
      check_val("t5 w0 cnt", 64'(pub_at(0, 0)), 64'd64);
      check_val("t5 done_o", 64'(done_o), 64'd0);
      check_val("t5 tready_idle", 64'(axis_if.tready), 64'd0);
      clear_mon();
      run_test("t5r", 5, 32'd10, 0, -1, -1, -1, -1, tb_first);
      idle_cycles(3);
      check_val("t5r lat_o", 64'(lat_o), 64'd5);
      check_val("t5r toggles", 64'(n_tog), 64'd1);
      check_val("t5r w0 cnt", 64'(pub_at(0, 0)), 64'd10);
      check_val("t5r done_o", 64'(done_o), 64'd1);
      test_en = 1'b0;
      idle_cycles(3);

      // Reset mid-RUN after window 0 has published.
      clear_mon();
      run_test("t6", 0, 32'd200, 0, -1, 80, -1, -1, tb_first);
      idle_cycles(1);
      check_val("t6 vld_o", 64'(vld_o), 64'd0);
      check_val("t6 cnt_o", 64'(cnt_o), 64'd0);
      check_val("t6 err_o", 64'(err_o), 64'd0);
      check_val("t6 idl_o", 64'(idl_o), 64'd0);
      check_val("t6 done_o", 64'(done_o), 64'd0);
      check_val("t6 tready", 64'(axis_if.tready), 64'd0);
      rst = 1'b0;
      idle_cycles(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/tst_dout_win_stats.md
Name: tst_dout_win_stats

Overview:
- Fast-clock (500 MHz) checker stage that sits directly upstream of the cross-clock results accumulator.
- Sinks the design's AXI-Stream output and compares each beat against a ramp pattern.
- Reduces activity to per-64-cycle window statistics: valid beats, errored beats, idle cycles, plus start-to-first-beat latency.
- Publishes each window with a toggle strobe, so the slow-clock accumulator can edge-detect and sum it.

Parameters:
- LANES, 4, number of 32-bit words per beat; data width = 32*LANES.
- WIN_LEN, 64, window length in clk cycles; must be a power of two, ≤ 64.

Ports:
- clk  in  1  500 MHz data clock
- rst  in  1  synchronous, active-high reset
- test_en  in  1  level; rising edge starts a test, low aborts/clears
- total_beats  in  32  beats expected per test; sampled on test_en rise; 0 treated as 1
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  high only in WAIT_FIRST and RUN
- s_axis_tdata  in  32*LANES  beat data; word k = bits [32k+31:32k]
- vld_o  out  1  toggles once per published window
- cnt_o  out  7  valid beats in the window (0..64)
- err_o  out  7  mismatching beats in the window (0..64)
- idl_o  out  12  idle cycles in the window (tvalid low while ready); upper bits zero
- lat_o  out  16  cycles from start to first beat, saturating
- done_o  out  1  level, high in DONE

Behaviour:
- Reset: state IDLE; vld_o=0, cnt_o=err_o=idl_o=0, lat_o=0, done_o=0, s_axis_tready=0; internal counters 0.
- test_en is registered once; start = rise of the registered copy; test_en low in any state → IDLE next cycle.
- IDLE → WAIT_FIRST on start, which also:
  - clears beat index n, lat counter and window accumulators;
  - latches total_beats;
  - leaves vld_o at its current level.
- WAIT_FIRST:
  - tready=1; lat counter +1 per cycle, saturating at 16'hFFFF;
  - first cycle with tvalid → RUN; that beat counts as beat 0 of window 0;
  - lat_o is loaded with the count at that cycle (start cycle counts as 0).
- RUN:
  - beat accepted = tvalid & tready;
  - expected word k of beat n = (n*LANES + k) mod 2^32;
  - beat errors if any word differs; err increments by at most 1 per beat;
  - n is 32 bits and wraps.
- Windows:
  - a window cycle counter in RUN increments each cycle;
  - at count WIN_LEN-1, the accumulators (including that cycle) are copied into cnt_o/err_o/idl_o, vld_o toggles, and accumulators restart at 0 on the next cycle.
  - Outputs change only on the same cycle vld_o toggles, then hold ≥ WIN_LEN cycles. This holds data stable across the consumer's 2-FF array sync.
- RUN → DONE when the accepted beat is number total_beats-1:
  - the partial window (including that beat) is published with a vld_o toggle on that cycle's register update;
  - tready drops the following cycle.
  - If this coincides with a window boundary, exactly one publish occurs.
- DONE: done_o=1; no further toggles; outputs hold until test_en low → IDLE (done_o=0; cnt/err/idl/lat outputs hold).
- A start while in DONE requires test_en to go low first; there is no re-arm without a falling edge.
- Abort mid-RUN (test_en low): the partial window is discarded, with no toggle.
- rst overrides everything in the same cycle.
- Latency through the block: beat at cycle t is reflected in outputs at t+1 at the earliest (window end).

Optional Feature:
- Macro TST_DOUT_ERR_CAPTURE_EN.
- Defined: adds ports first_err_idx_o (out 32) and first_err_data_o (out 32*LANES).
  - On the first errored beat after start, these capture n and tdata.
  - They hold until the next start; cleared to 0 by rst and on start.
- Undefined: ports and capture logic absent; behaviour otherwise identical.

Test Plan:
- Clean ramp, total_beats=256, tvalid stuck 1 after a 10-cycle gap:
  - lat_o=10;
  - four toggles with cnt_o=64, err_o=0, idl_o=0;
  - a fifth toggle? No: the 256th beat lands on a window end, so exactly 4 toggles; then done_o=1.
- Same, but tvalid low every 4th cycle, total_beats=96:
  - windows report cnt_o=48/idl_o=16, then a final partial window cnt_o=48 with idl_o=15 or 16 per exact cycle;
  - totals sum cnt=96.
- Corrupt word 2 of beats 5 and 70 (total_beats=128, continuous):
  - err_o=1 in window 0 and in window 1;
  - with TST_DOUT_ERR_CAPTURE_EN, first_err_idx_o=5.
- No tvalid for 70000 cycles after start: lat_o=16'hFFFF, with no vld_o toggle before the first beat.
- test_en dropped after 100 beats of 200:
  - no partial toggle, done_o stays 0, state IDLE;
  - restart gives lat counted from the new rising edge.
- rst asserted mid-RUN: all outputs return to reset values next cycle; tready=0.
